// File: rtl/pcm_mem_arbiter.sv
// Four-CPU round-robin arbiter in front of a single-port PCM memory.
// Only one access is in flight; out-of-range addresses complete without a memory strobe.
module pcm_mem_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        cpu_ce_n,
  input  logic [3:0]        cpu_oe_n,
  input  logic [3:0]        cpu_we_n,
  input  logic [3:0]        cpu_ub_n,
  input  logic [3:0]        cpu_lb_n,
  input  logic [63:0]       cpu_addr,
  input  logic [63:0]       cpu_wdata,
  output logic [63:0]       cpu_rdata,
  output logic [3:0]        cpu_ack,
  output logic [ADDR_W-1:0] pcm_mem_mm_address,
  output logic              pcm_mem_mm_chipselect,
  output logic              pcm_mem_mm_clken,
  output logic              pcm_mem_mm_write,
  output logic [DATA_W-1:0] pcm_mem_mm_writedata,
  output logic [1:0]        pcm_mem_mm_byteenable,
  input  logic [DATA_W-1:0] pcm_mem_mm_readdata,
  output logic              busy,
  output logic [3:0]        err
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RWAIT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [1:0]        r_last_grant;
  logic [1:0]        r_grant;
  logic [3:0]        r_armed;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wdata;
  logic [1:0]        r_be;
  logic              r_wr;
  logic [CNT_W-1:0]  r_rcnt;
  logic [63:0]       r_rdata;
  logic [3:0]        r_err;

  logic [3:0]        w_req;
  logic              w_gnt_found;
  logic [1:0]        w_gnt_idx;
  logic [15:0]       w_sel_addr;
  logic [15:0]       w_sel_wdata;
  logic              w_sel_wr;
  logic [1:0]        w_sel_be;
  logic              w_sel_oor;
  logic [15:0]       w_rd16;

  // A CPU only competes while armed: one held request yields exactly one access.
  for (genvar gi = 0; gi < 4; gi++) begin : g_cpu
    assign w_req[gi]   = ~cpu_ce_n[gi] & (~cpu_oe_n[gi] | ~cpu_we_n[gi]) & r_armed[gi];
    assign cpu_ack[gi] = (r_state == S_DONE) && (r_grant == 2'(gi));
  end

  // Search downward so the candidate nearest last_grant+1 is the one left standing.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = r_last_grant;
    for (int k = 4; k >= 1; k--) begin
      if (w_req[r_last_grant + 2'(k)]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = r_last_grant + 2'(k);
      end
    end
  end

  assign w_sel_addr  = cpu_addr[{w_gnt_idx, 4'b0000} +: 16];
  assign w_sel_wdata = cpu_wdata[{w_gnt_idx, 4'b0000} +: 16];
  assign w_sel_wr    = ~cpu_we_n[w_gnt_idx];
  assign w_sel_be    = {~cpu_ub_n[w_gnt_idx], ~cpu_lb_n[w_gnt_idx]};
  assign w_sel_oor   = (w_sel_addr >> ADDR_W) != 16'd0;
  assign w_rd16      = 16'(pcm_mem_mm_readdata);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next          = r_state;
    pcm_mem_mm_chipselect = 1'b0;
    pcm_mem_mm_clken      = 1'b0;
    pcm_mem_mm_write      = 1'b0;
    pcm_mem_mm_address    = '0;
    pcm_mem_mm_writedata  = '0;
    pcm_mem_mm_byteenable = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_found) begin
          w_state_next = w_sel_oor ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        pcm_mem_mm_chipselect = 1'b1;
        pcm_mem_mm_clken      = 1'b1;
        pcm_mem_mm_write      = r_wr;
        pcm_mem_mm_address    = r_addr;
        pcm_mem_mm_writedata  = DATA_W'(r_wdata);
        pcm_mem_mm_byteenable = r_be;
        w_state_next          = r_wr ? S_DONE : S_RWAIT;
      end
      S_RWAIT: begin
        pcm_mem_mm_clken = 1'b1;
        if (r_rcnt == '0) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant <= 2'd3;
      r_grant      <= 2'd0;
      r_addr       <= '0;
      r_wdata      <= 16'h0000;
      r_be         <= 2'b00;
      r_wr         <= 1'b0;
      r_rcnt       <= '0;
      r_rdata      <= 64'h0;
      r_err        <= 4'b0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_found) begin
            r_grant <= w_gnt_idx;
            r_addr  <= w_sel_addr[ADDR_W-1:0];
            r_wdata <= w_sel_wdata;
            r_be    <= w_sel_be;
            r_wr    <= w_sel_wr;
            // Out-of-range reads return zero, visible together with the ack.
            if (w_sel_oor) begin
              r_err[w_gnt_idx] <= 1'b1;
              if (!w_sel_wr) begin
                r_rdata[{w_gnt_idx, 4'b0000} +: 16] <= 16'h0000;
              end
            end
          end
        end
        S_ISSUE: begin
          r_rcnt <= CNT_W'(RD_LAT - 1);
        end
        S_RWAIT: begin
          if (r_rcnt == '0) begin
            r_rdata[{r_grant, 4'b0000} +: 16] <= w_rd16;
          end else begin
            r_rcnt <= r_rcnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          r_last_grant <= r_grant;
        end
        default: begin
        end
      endcase
    end
  end

  // Re-arm wins over the ack clear: a CPU that already let go may ask again.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_armed <= 4'b1111;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cpu_ce_n[i]) begin
          r_armed[i] <= 1'b1;
        end else if (cpu_ack[i]) begin
          r_armed[i] <= 1'b0;
        end
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign cpu_rdata = r_rdata;
  assign err       = r_err;

endmodule
